// File: rtl/gpsreceiver3_ctlif_pkg.sv
// Shared constants for the GPS receiver control interface: CSR word indices,
// the ID value and the Gray-to-binary conversion.
package gpsreceiver3_pkg;

   localparam logic [5:0] IDX_ENABLE   = 6'h00;
   localparam logic [5:0] IDX_RESET    = 6'h01;
   localparam logic [5:0] IDX_SNAP     = 6'h02;
   localparam logic [5:0] IDX_IRQ_STAT = 6'h03;
   localparam logic [5:0] IDX_IRQ_MASK = 6'h04;
   localparam logic [5:0] IDX_ID       = 6'h05;

   // Per-channel register groups occupy index[5:3]; index[2:0] is the channel.
   localparam logic [2:0] GRP_SNAPCNT  = 3'b001;
   localparam logic [2:0] GRP_LIVECNT  = 3'b010;
   localparam logic [2:0] GRP_THRESH   = 3'b011;

   localparam logic [31:0] ID_VALUE    = 32'h47505333;

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gpsreceiver3_ctlif_if.sv
// CSR bus between a host master and the GPS receiver control interface.
interface gpsreceiver3_ctlif_if;
   logic [14:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;

   modport master (output csr_a, output csr_we, output csr_di, input csr_do);
   modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/gpsreceiver3_ctlif_gray_sync.sv
// One channel's count crossing: two-flop synchroniser on the Gray code,
// then a registered Gray-to-binary conversion (three cycles end to end).
module gpsreceiver3_gray_sync
   import gpsreceiver3_pkg::*;
#(
   parameter int CW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] gray_in,
   output logic [CW-1:0] bin_out
);

   logic [CW-1:0] s1_q, s1_d;
   logic [CW-1:0] s2_q, s2_d;
   logic [CW-1:0] bin_q, bin_d;
   logic [31:0]   gray32_s;

   // Next-state: shift through the synchroniser and convert the settled code.
   always_comb begin
      s1_d     = gray_in;
      s2_d     = s1_q;
      gray32_s = 32'h0;
      gray32_s[CW-1:0] = s2_q;
      bin_d    = CW'(gray2bin(gray32_s));
   end

   // Synchroniser and conversion registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q  <= '0;
         s2_q  <= '0;
         bin_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         bin_q <= bin_d;
      end
   end

   assign bin_out = bin_q;

endmodule

// File: rtl/gpsreceiver3_ctlif.sv
// CSR control interface for the GPS receiver channels: enables, reset pulses,
// coherent count snapshots and threshold interrupts (GPSRECEIVER3_CTLIF_IRQ_EN).
module gpsreceiver3_ctlif
   import gpsreceiver3_pkg::*;
#(
   parameter logic [4:0] csr_addr = 5'h0,
   parameter int         NCH      = 4,
   parameter int         CW       = 11
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   gpsreceiver3_ctlif_if.slave csr,
   input  logic [NCH*CW-1:0]   rx_count_gray,
   output logic [NCH-1:0]      r_enable,
   output logic [NCH-1:0]      r_reset,
   output logic                irq
);

   logic [CW-1:0]  live_s [NCH];
   logic           sel_s, wr_s;
   logic [5:0]     idx_s;
   logic [2:0]     grp_s, ch_s;
   logic [31:0]    rdata_s;
   logic           csr_unused_s;

   logic [NCH-1:0] enable_q, enable_d;
   logic [NCH-1:0] reset_q, reset_d;
   logic [15:0]    seq_q, seq_d;
   logic [CW-1:0]  snap_q [NCH];
   logic [CW-1:0]  snap_d [NCH];
   logic [31:0]    csr_do_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      gpsreceiver3_gray_sync #(.CW(CW)) u_sync (
         .clk     (sys_clk),
         .rst     (sys_rst),
         .gray_in (rx_count_gray[g*CW +: CW]),
         .bin_out (live_s[g])
      );
   end

   assign sel_s        = (csr.csr_a[14:10] == csr_addr);
   assign wr_s         = sel_s & csr.csr_we;
   assign idx_s        = csr.csr_a[5:0];
   assign grp_s        = idx_s[5:3];
   assign ch_s         = idx_s[2:0];
   assign csr_unused_s = ^{csr.csr_a[9:6], csr.csr_di};

`ifdef GPSRECEIVER3_CTLIF_IRQ_EN
   logic [NCH-1:0] stat_q, stat_d;
   logic [NCH-1:0] mask_q, mask_d;
   logic [NCH-1:0] below_q, below_d;
   logic           irq_q, irq_d;
   logic [CW-1:0]  thresh_q [NCH];
   logic [CW-1:0]  thresh_d [NCH];

   // Interrupt next-state: register writes, then crossing sets override W1C.
   always_comb begin
      stat_d   = stat_q;
      mask_d   = mask_q;
      thresh_d = thresh_q;
      for (int i = 0; i < NCH; i++) begin
         below_d[i] = (live_s[i] < thresh_q[i]);
      end
      if (wr_s) begin
         case (idx_s)
            IDX_IRQ_STAT: stat_d = stat_q & ~csr.csr_di[NCH-1:0];
            IDX_IRQ_MASK: mask_d = csr.csr_di[NCH-1:0];
            default: begin
               for (int i = 0; i < NCH; i++) begin
                  if (idx_s == {GRP_THRESH, 3'(i)}) begin
                     thresh_d[i] = csr.csr_di[CW-1:0];
                  end else begin
                     thresh_d[i] = thresh_q[i];
                  end
               end
            end
         endcase
      end else begin
         stat_d = stat_q;
      end
      stat_d = stat_d | (enable_q & below_q & ~below_d);
      irq_d  = |(stat_q & mask_q);
   end

   // Interrupt state registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         stat_q   <= '0;
         mask_q   <= '0;
         below_q  <= '0;
         irq_q    <= 1'b0;
         thresh_q <= '{default: '1};
      end else begin
         stat_q   <= stat_d;
         mask_q   <= mask_d;
         below_q  <= below_d;
         irq_q    <= irq_d;
         thresh_q <= thresh_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   // Control next-state and read mux; reads always see pre-write state.
   always_comb begin
      enable_d = enable_q;
      reset_d  = '0;
      seq_d    = seq_q;
      snap_d   = snap_q;
      rdata_s  = 32'h0;
      if (wr_s) begin
         case (idx_s)
            IDX_ENABLE: enable_d = csr.csr_di[NCH-1:0];
            IDX_RESET:  reset_d  = csr.csr_di[NCH-1:0];
            IDX_SNAP: begin
               seq_d  = seq_q + 16'd1;
               snap_d = live_s;
            end
            default:    enable_d = enable_q;
         endcase
      end else begin
         enable_d = enable_q;
      end
      if (sel_s) begin
         case (idx_s)
            IDX_ENABLE:   rdata_s = 32'(enable_q);
            IDX_SNAP:     rdata_s = 32'(seq_q);
            IDX_ID:       rdata_s = ID_VALUE;
`ifdef GPSRECEIVER3_CTLIF_IRQ_EN
            IDX_IRQ_STAT: rdata_s = 32'(stat_q);
            IDX_IRQ_MASK: rdata_s = 32'(mask_q);
`endif
            default: begin
               for (int i = 0; i < NCH; i++) begin
                  if (ch_s == 3'(i)) begin
                     case (grp_s)
                        GRP_SNAPCNT: rdata_s = 32'(snap_q[i]);
                        GRP_LIVECNT: rdata_s = 32'(live_s[i]);
`ifdef GPSRECEIVER3_CTLIF_IRQ_EN
                        GRP_THRESH:  rdata_s = 32'(thresh_q[i]);
`endif
                        default:     rdata_s = rdata_s;
                     endcase
                  end else begin
                     rdata_s = rdata_s;
                  end
               end
            end
         endcase
      end else begin
         rdata_s = 32'h0;
      end
   end

   // Control, snapshot and read-data registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         enable_q <= '1;
         reset_q  <= '0;
         seq_q    <= 16'h0;
         snap_q   <= '{default: '0};
         csr_do_q <= 32'h0;
      end else begin
         enable_q <= enable_d;
         reset_q  <= reset_d;
         seq_q    <= seq_d;
         snap_q   <= snap_d;
         csr_do_q <= rdata_s;
      end
   end

   assign csr.csr_do = csr_do_q;
   assign r_enable   = enable_q;
   assign r_reset    = reset_q;

endmodule

// File: tb/tb_gpsreceiver3_ctlif.sv
// Self-checking bench for gpsreceiver3_ctlif (NCH=4, CW=11); expectations
// follow GPSRECEIVER3_CTLIF_IRQ_EN when it is defined.
module tb_gpsreceiver3_ctlif;

`ifdef GPSRECEIVER3_CTLIF_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic [43:0] rx_count_gray;
   logic [3:0]  r_enable;
   logic [3:0]  r_reset;
   logic        irq;
   int          checks = 0;
   int          failures = 0;

   logic [31:0] exp_q [$];
   string       nm_q [$];

   gpsreceiver3_ctlif_if csr_bus ();

   gpsreceiver3_ctlif #(.csr_addr(5'h0), .NCH(4), .CW(11)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .csr           (csr_bus),
      .rx_count_gray (rx_count_gray),
      .r_enable      (r_enable),
      .r_reset       (r_reset),
      .irq           (irq)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [14:0] a;
      logic        we;
      logic [31:0] di;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [15];

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [10:0] gray(input logic [10:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic set_ch(input int ch, input logic [10:0] val);
      rx_count_gray[ch*11 +: 11] = gray(val);
   endtask

   task automatic rd(input logic [5:0] idx, input logic [31:0] exp, input string nm);
      csr_bus.csr_a  = {5'h0, 4'h0, idx};
      csr_bus.csr_we = 1'b0;
      exp_q.push_back(exp);
      nm_q.push_back(nm);
      tick();
      check(nm_q.pop_front(), csr_bus.csr_do, exp_q.pop_front());
   endtask

   task automatic wr(input logic [5:0] idx, input logic [31:0] di);
      csr_bus.csr_a  = {5'h0, 4'h0, idx};
      csr_bus.csr_di = di;
      csr_bus.csr_we = 1'b1;
      tick();
      csr_bus.csr_we = 1'b0;
   endtask

   initial begin
      csr_bus.csr_a  = 15'h0;
      csr_bus.csr_we = 1'b0;
      csr_bus.csr_di = 32'h0;
      rx_count_gray  = 44'h0;

      tbl[0]  = '{15'h0000, 1'b0, 32'h0,        32'h0000000F};
      tbl[1]  = '{15'h0001, 1'b0, 32'h0,        32'h0};
      tbl[2]  = '{15'h0002, 1'b0, 32'h0,        32'h0};
      tbl[3]  = '{15'h0005, 1'b0, 32'h0,        32'h47505333};
      tbl[4]  = '{15'h003F, 1'b0, 32'h0,        32'h0};
      tbl[5]  = '{15'h0003, 1'b0, 32'h0,        32'h0};
      tbl[6]  = '{15'h0004, 1'b0, 32'h0,        32'h0};
      tbl[7]  = '{15'h0018, 1'b0, 32'h0,        IRQ_ON ? 32'h000007FF : 32'h0};
      tbl[8]  = '{15'h000C, 1'b0, 32'h0,        32'h0};
      tbl[9]  = '{15'h0010, 1'b0, 32'h0,        32'h0};
      tbl[10] = '{15'h0405, 1'b0, 32'h0,        32'h0};
      tbl[11] = '{15'h0006, 1'b0, 32'h0,        32'h0};
      tbl[12] = '{15'h0000, 1'b1, 32'hFFFFFFFA, 32'h0000000F};
      tbl[13] = '{15'h0000, 1'b0, 32'h0,        32'h0000000A};
      tbl[14] = '{15'h0000, 1'b1, 32'h0000000F, 32'h0000000A};

      // Reset state
      sys_rst = 1'b1;
      #3;
      check("rst_enable", {28'h0, r_enable}, 32'hF);
      check("rst_reset", {28'h0, r_reset}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      check("rst_csr_do", csr_bus.csr_do, 32'h0);
      tick();
      tick();
      sys_rst = 1'b0;
      tick();

      // Register map vectors
      for (int i = 0; i < 15; i++) begin
         csr_bus.csr_a  = tbl[i].a;
         csr_bus.csr_we = tbl[i].we;
         csr_bus.csr_di = tbl[i].di;
         exp_q.push_back(tbl[i].exp);
         nm_q.push_back($sformatf("vec%0d", i));
         tick();
         check(nm_q.pop_front(), csr_bus.csr_do, exp_q.pop_front());
      end
      csr_bus.csr_we = 1'b0;
      check("enable_restored", {28'h0, r_enable}, 32'hF);

      // Live count latency and coherent snapshot
      set_ch(2, 11'h2A5);
      tick();
      tick();
      rd(6'h12, 32'h0, "live2_early");
      rd(6'h12, 32'h2A5, "live2_valid");
      wr(IDX_SNAP_T(), 32'h0);
      check("snap_pre_seq", csr_bus.csr_do, 32'h0);
      rd(6'h0A, 32'h2A5, "snapcnt2");
      rd(6'h08, 32'h0, "snapcnt0");
      rd(6'h02, 32'h1, "seq_one");

      // Reset pulse and its termination by sys_rst
      wr(6'h01, 32'h5);
      check("rreset_pulse", {28'h0, r_reset}, 32'h5);
      tick();
      check("rreset_end", {28'h0, r_reset}, 32'h0);
      wr(6'h01, 32'h5);
      check("rreset_pulse2", {28'h0, r_reset}, 32'h5);
      #2;
      sys_rst = 1'b1;
      #1;
      check("rreset_killed", {28'h0, r_reset}, 32'h0);
      tick();
      sys_rst = 1'b0;
      tick();
      rd(6'h02, 32'h0, "seq_after_rst");

      // Threshold crossing interrupt
      set_ch(1, 11'd99);
      wr(6'h19, 32'd100);
      wr(6'h04, 32'h2);
      repeat (5) tick();
      rd(6'h03, 32'h0, "stat_below");
      set_ch(1, 11'd100);
      repeat (4) tick();
      check("irq_not_yet", {31'h0, irq}, 32'h0);
      tick();
      check("irq_raised", {31'h0, irq}, {31'h0, IRQ_ON});
      rd(6'h03, IRQ_ON ? 32'h2 : 32'h0, "stat_cross");
      rd(6'h04, IRQ_ON ? 32'h2 : 32'h0, "mask_rb");
      rd(6'h19, IRQ_ON ? 32'd100 : 32'h0, "thresh1_rb");

      // Re-arm, clear, then W1C colliding with a new crossing
      set_ch(1, 11'd50);
      repeat (5) tick();
      wr(6'h03, 32'h2);
      rd(6'h03, 32'h0, "stat_cleared");
      check("irq_cleared", {31'h0, irq}, 32'h0);
      set_ch(1, 11'd100);
      tick();
      tick();
      tick();
      wr(6'h03, 32'h2);
      rd(6'h03, IRQ_ON ? 32'h2 : 32'h0, "stat_set_wins");
      check("irq_set_wins", {31'h0, irq}, {31'h0, IRQ_ON});

      // Disabling keeps status but blocks new sets
      wr(6'h00, 32'hD);
      rd(6'h03, IRQ_ON ? 32'h2 : 32'h0, "stat_kept_disabled");
      wr(6'h03, 32'h2);
      set_ch(1, 11'd50);
      repeat (5) tick();
      set_ch(1, 11'd100);
      repeat (5) tick();
      rd(6'h03, 32'h0, "stat_suppressed");
      wr(6'h00, 32'hF);

      // Sequence wrap
      csr_bus.csr_a  = 15'h0002;
      csr_bus.csr_we = 1'b1;
      repeat (65535) tick();
      csr_bus.csr_we = 1'b0;
      rd(6'h02, 32'h0000FFFF, "seq_max");
      wr(6'h02, 32'h0);
      rd(6'h02, 32'h0, "seq_wrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic logic [5:0] IDX_SNAP_T();
      return 6'h02;
   endfunction

endmodule

// File: doc/gpsreceiver3_ctlif.md
GPSRECEIVER3_CTLIF -- requirements
Module: gpsreceiver3_ctlif

Interface
REQ-001 SHALL have parameter csr_addr, default 5'h0, meaning CSR bank select compared against csr_a[14:10].
REQ-002 SHALL have parameter NCH, default 4, meaning number of channels (1..8).
REQ-003 SHALL have parameter CW, default 11, meaning per-channel count width (1..32).
REQ-004 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-005 sys_rst  in  1  asynchronous, active-high reset.
REQ-006 csr_a  in  15  CSR address.
REQ-007 csr_we  in  1  CSR write strobe.
REQ-008 csr_di  in  32  CSR write data.
REQ-009 csr_do  out  32  CSR read data, registered.
REQ-010 rx_count_gray  in  NCH*CW  per-channel Gray-coded counts from the sample domain; channel i at bits [i*CW +: CW].
REQ-011 r_enable  out  NCH  per-channel enable.
REQ-012 r_reset  out  NCH  per-channel reset pulse.
REQ-013 irq  out  1  level interrupt.

Function
REQ-014 Bank selected when csr_a[14:10]==csr_addr; word index = csr_a[5:0].
REQ-015 Read latency is one cycle; csr_do SHALL be 0 when not selected or when the index is unmapped; bits above the field width read 0.
REQ-016 Map: 0x00 ENABLE (RW, NCH bits); 0x01 RESET (write-1 pulse, reads 0); 0x02 SNAP (any write latches; reads the 16-bit snapshot sequence number); 0x03 IRQ_STAT (W1C); 0x04 IRQ_MASK (RW); 0x05 ID (RO, 32'h47505333); 0x08+i SNAPCNT[i] (RO); 0x10+i LIVECNT[i] (RO); 0x18+i THRESH[i] (RW, CW bits); i<NCH, otherwise unmapped.
REQ-017 Each channel: two-flop synchroniser on the Gray input, then registered Gray-to-binary; LIVECNT is valid 3 cycles after the input is stable.
REQ-018 A RESET write SHALL assert r_reset[i] for exactly one cycle, the cycle after the write, for each set bit of csr_di[NCH-1:0].
REQ-019 A SNAP write SHALL copy all NCH LIVECNT values into SNAPCNT in the same cycle, so the snapshot is coherent; the sequence number increments by 1 and wraps 0xFFFF->0.
REQ-020 A SNAP write in the same cycle as a read of SNAPCNT SHALL return the pre-snapshot value.
REQ-021 IRQ_STAT[i] SHALL set when r_enable[i]=1 and LIVECNT[i] goes from <THRESH[i] on the previous cycle to >=THRESH[i] (unsigned); a counter wrap that drops below the threshold re-arms the crossing.
REQ-022 A set event and a W1C of the same bit in the same cycle: set wins.
REQ-023 irq = |(IRQ_STAT & IRQ_MASK), registered (one cycle after the status/mask change).
REQ-024 Disabling a channel does not clear its IRQ_STAT; it only suppresses new sets.

Reset
REQ-025 On sys_rst: csr_do=0, r_enable=all ones, r_reset=0, irq=0, IRQ_STAT=0, IRQ_MASK=0, THRESH=all ones, SNAPCNT=0, sequence=0, synchronisers=0.
REQ-026 A reset asserted mid-pulse SHALL terminate the r_reset pulse immediately.

Configuration
REQ-027 Macro GPSRECEIVER3_CTLIF_IRQ_EN: when defined, REQ-021..024 are implemented.
REQ-028 When it is undefined: irq is tied 0; IRQ_STAT, IRQ_MASK and THRESH read 0 and ignore writes; no comparators are built.

Structure
REQ-029 Package gpsreceiver3_pkg SHALL hold the register index constants, the ID value and the Gray-to-binary function.
REQ-030 Sub-module gpsreceiver3_gray_sync (one instance per channel via generate): synchroniser plus registered conversion.

Verification
REQ-031 Reset, then read 0x00 with NCH=4 -> 0x0000000F; read 0x05 -> 0x47505333; read 0x3F -> 0.
REQ-032 Drive Gray(0x2A5) on ch2 -> LIVECNT[2]=0x2A5 exactly 3 cycles later; write SNAP -> SNAPCNT[2]=0x2A5, SNAP reads 1.
REQ-033 Write 0x01 with 0x5 -> r_reset=4'b0101 for exactly one cycle; apply sys_rst during the pulse -> r_reset=0 immediately.
REQ-034 THRESH[1]=100, mask=0x2, ramp ch1 99->100 -> IRQ_STAT=0x2 and irq=1 one cycle later; W1C on the same cycle as a new crossing -> bit stays 1.
REQ-035 Build without GPSRECEIVER3_CTLIF_IRQ_EN, repeat REQ-034 -> irq stays 0 and 0x03/0x04/0x19 read 0.
REQ-036 Sequence at 0xFFFF, write SNAP -> reads 0x0000.
